// File: rtl/multdiv_pkg.sv
// Shared constants and state encoding for the multiply/divide unit.
// Build option: MULT_BOOTH_RADIX4_EN selects radix-4 modified Booth in mult
// (2 bits per step, 16 steps); undefined gives radix-2 Booth (32 steps).
package multdiv_pkg;

  localparam int WIDTH    = 32;
  localparam int CNT_W    = 6;
  localparam int STEPS_R2 = 32;
  localparam int STEPS_R4 = 16;

  // Common FSM encoding for both halves of the unit.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

`ifdef MULT_BOOTH_RADIX4_EN
  localparam int STEP_BITS = 2;
  localparam int GUARD     = 2;
  localparam int NUM_STEPS = STEPS_R4;
`else
  localparam int STEP_BITS = 1;
  localparam int GUARD     = 1;
  localparam int NUM_STEPS = STEPS_R2;
`endif

  // Accumulator carries guard bits so adding +/-A (or +/-2A) never wraps.
  localparam int ACC_W    = WIDTH + GUARD;
  // Booth recoding window: STEP_BITS multiplier bits plus q(-1).
  localparam int RECODE_W = STEP_BITS + 1;
  // Full product register: accumulator | multiplier | q(-1).
  localparam int PROD_W   = ACC_W + WIDTH + 1;

endpackage

// File: rtl/mult_booth_sel.sv
// Booth partial-product selector for mult (combinational).
// Build option: MULT_BOOTH_RADIX4_EN selects {0,+-A,+-2A} from a 3-bit window;
// otherwise {0,+-A} from a 2-bit window. Output is sign-extended to ACC_W.
module mult_booth_sel
  import multdiv_pkg::*;
(
  input  logic [RECODE_W-1:0] booth_bits_i,
  input  logic [WIDTH-1:0]    mcand_i,
  output logic [ACC_W-1:0]    pp_o
);

  logic [ACC_W-1:0] a_ext;

  assign a_ext = {{GUARD{mcand_i[WIDTH-1]}}, mcand_i};

  // Map the recoding window onto the signed multiple of A to accumulate.
  always_comb begin
    pp_o = '0;
`ifdef MULT_BOOTH_RADIX4_EN
    case (booth_bits_i)
      3'b001, 3'b010: pp_o = a_ext;
      3'b011:         pp_o = a_ext << 1;
      3'b100:         pp_o = -(a_ext << 1);
      3'b101, 3'b110: pp_o = -a_ext;
      default:        pp_o = '0;
    endcase
`else
    case (booth_bits_i)
      2'b01:   pp_o = a_ext;
      2'b10:   pp_o = -a_ext;
      default: pp_o = '0;
    endcase
`endif
  end

endmodule

// File: rtl/mult.sv
// Sequential signed 32x32 Booth multiplier (low word + signed overflow).
// Build option: MULT_BOOTH_RADIX4_EN -> 16 radix-4 steps, else 32 radix-2 steps.
// Handshake: ctrl_MULT is a one-cycle start; operands are sampled on the same
// edge. A start in any state (including BUSY and DONE) aborts the current
// operation and restarts. data_resultRDY is high for exactly one cycle when
// data_result/data_exception become valid; those hold until the next result.
module mult
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  logic [ACC_W-1:0]        pp;
  logic [ACC_W-1:0]        sum;
  logic signed [PROD_W-1:0] combined_s;
  logic signed [PROD_W-1:0] shifted_s;
  logic [ACC_W-1:0]        step_acc;
  logic [WIDTH-1:0]        step_mplr;
  logic                    step_qm1;
  logic                    step_exc;

  mult_booth_sel u_booth_sel (
    .booth_bits_i ({mplr_q[STEP_BITS-1:0], qm1_q}),
    .mcand_i      (mcand_q),
    .pp_o         (pp)
  );

  // One Booth step: add the selected multiple, then arithmetic-shift the
  // whole product register right by the radix width.
  assign sum        = acc_q + pp;
  assign combined_s = {sum, mplr_q, qm1_q};
  assign shifted_s  = combined_s >>> STEP_BITS;
  assign step_acc   = shifted_s[PROD_W-1 -: ACC_W];
  assign step_mplr  = shifted_s[WIDTH:1];
  assign step_qm1   = shifted_s[0];
  // After the last step the 64-bit product is {acc[31:0], mplr}; overflow when
  // the high word is not a pure sign extension of bit 31.
  assign step_exc   = (step_acc[WIDTH-1:0] != {WIDTH{step_mplr[WIDTH-1]}});

  // Next-state and datapath control; a start always wins over the current state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mplr_d   = mplr_q;
    qm1_d    = qm1_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    exc_d    = exc_q;
    if (ctrl_MULT) begin
      state_d = BUSY;
      cnt_d   = CNT_W'(NUM_STEPS);
      acc_d   = '0;
      mplr_d  = data_operandB;
      qm1_d   = 1'b0;
      mcand_d = data_operandA;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        BUSY: begin
          acc_d  = step_acc;
          mplr_d = step_mplr;
          qm1_d  = step_qm1;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = DONE;
            result_d = step_mplr;
            exc_d    = step_exc;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mplr_q   <= '0;
      qm1_q    <= 1'b0;
      mcand_q  <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mplr_q   <= mplr_d;
      qm1_q    <= qm1_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);

endmodule

// File: tb/tb_mult.sv
// Self-checking bench for mult: directed cases, abort/restart, async reset
// mid-operation, back-to-back starts and random signed operands checked
// against a 64-bit arithmetic reference.
module tb_mult;

`ifdef MULT_BOOTH_RADIX4_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 32;
`endif

  logic        clock;
  logic        reset;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        ctrl_mult;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int n_checks = 0;
  int n_errors = 0;

  // Expected {exception, result} per accepted start, oldest first.
  logic [32:0] exp_q[$];

  mult dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .ctrl_MULT      (ctrl_mult),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  // Clock and watchdog.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: full signed product, low word plus overflow of the 64-bit value.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [63:0] pu;
    logic        ovf;
    p   = longint'($signed(a)) * longint'($signed(b));
    pu  = p;
    ovf = (p < -longint'(64'h8000_0000)) || (p > longint'(64'h7FFF_FFFF));
    return {ovf, pu[31:0]};
  endfunction

  // Drive a start pulse (called #1 after an edge); returns #1 after edge 0.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [32:0] exp);
    ctrl_mult = 1'b1;
    op_a      = a;
    op_b      = b;
    exp_q.push_back(exp);
    @(posedge clock); #1;
    ctrl_mult = 1'b0;
    op_a      = $urandom;
    op_b      = $urandom;
  endtask

  // Wait (bounded) for the ready pulse, check latency and scoreboard entry.
  task automatic wait_ready(input string tag);
    int n;
    logic [32:0] exp;
    n = 0;
    while (!data_resultRDY && n < LAT + 8) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(LAT));
    if (data_resultRDY) begin
      check({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        check({tag, "_result"}, 64'(data_result), 64'(exp[31:0]));
        check({tag, "_exc"}, 64'(data_exception), 64'(exp[32]));
      end
    end
  endtask

  // After a ready cycle: pulse must drop and outputs must hold.
  task automatic check_pulse_end(input string tag);
    logic [31:0] r;
    logic        e;
    r = data_result;
    e = data_exception;
    @(posedge clock); #1;
    check({tag, "_rdy_drop"}, 64'(data_resultRDY), 64'd0);
    check({tag, "_hold"}, 64'({data_exception, data_result}), 64'({e, r}));
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [32:0] exp);
    start_op(a, b, exp);
    check({tag, "_rdy_low_busy"}, 64'(data_resultRDY), 64'd0);
    wait_ready(tag);
    check_pulse_end(tag);
  endtask

  logic [31:0] dir_a [6] = '{32'd3, 32'hFFFF_FFF9, 32'h8000_0000, 32'h7FFF_FFFF,
                             32'h8000_0000, 32'h0001_0000};
  logic [31:0] dir_b [6] = '{32'd4, 32'd6, 32'd1, 32'd2, 32'hFFFF_FFFF, 32'h0001_0000};
  logic [32:0] dir_e [6] = '{{1'b0, 32'h0000_000C}, {1'b0, 32'hFFFF_FFD6},
                             {1'b0, 32'h8000_0000}, {1'b1, 32'hFFFF_FFFE},
                             {1'b1, 32'h8000_0000}, {1'b1, 32'h0000_0000}};

  initial begin
    logic saw;
    logic [31:0] ra, rb;
    int mode;

    reset     = 1'b1;
    ctrl_mult = 1'b0;
    op_a      = '0;
    op_b      = '0;
    #12;
    check("reset_result", 64'(data_result), 64'd0);
    check("reset_exc", 64'(data_exception), 64'd0);
    check("reset_rdy", 64'(data_resultRDY), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Directed products.
    for (int i = 0; i < 6; i++) run_op($sformatf("dir%0d", i), dir_a[i], dir_b[i], dir_e[i]);

    // Abort: 5x5 restarted at edge 10 with 2x9; only one ready pulse.
    start_op(32'd5, 32'd5, model(32'd5, 32'd5));
    saw = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clock); #1;
      saw |= data_resultRDY;
    end
    check("abort_no_early_rdy", 64'(saw), 64'd0);
    exp_q.delete();
    start_op(32'd2, 32'd9, {1'b0, 32'h0000_0012});
    wait_ready("abort");
    check_pulse_end("abort");
    saw = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(posedge clock); #1;
      saw |= data_resultRDY;
    end
    check("abort_single_pulse", 64'(saw), 64'd0);

    // Asynchronous reset mid-BUSY clears outputs immediately, no pulse.
    start_op(32'd123, 32'hFFFF_FF00, model(32'd123, 32'hFFFF_FF00));
    repeat (5) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("midrst_result", 64'(data_result), 64'd0);
    check("midrst_exc", 64'(data_exception), 64'd0);
    check("midrst_rdy", 64'(data_resultRDY), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    saw = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(posedge clock); #1;
      saw |= data_resultRDY;
    end
    check("midrst_no_rdy", 64'(saw), 64'd0);
    run_op("post_rst", 32'd1, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFF});

    // Back-to-back: start during the ready cycle.
    start_op(32'd1000, 32'd1000, model(32'd1000, 32'd1000));
    wait_ready("b2b_first");
    start_op(32'hFFFF_FFFE, 32'h4000_0000, model(32'hFFFF_FFFE, 32'h4000_0000));
    check("b2b_rdy_drop", 64'(data_resultRDY), 64'd0);
    wait_ready("b2b_second");
    check_pulse_end("b2b_second");

    // Random signed operands.
    for (int i = 0; i < 200; i++) begin
      mode = $urandom_range(0, 3);
      ra = $urandom;
      rb = $urandom;
      if (mode == 1) begin
        ra = 32'($signed($urandom_range(0, 200)) - 100);
        rb = 32'($signed($urandom_range(0, 200)) - 100);
      end else if (mode == 2) begin
        case ($urandom_range(0, 3))
          0: ra = 32'h8000_0000;
          1: ra = 32'h7FFF_FFFF;
          2: ra = 32'h0000_0000;
          default: ra = 32'hFFFF_FFFF;
        endcase
      end else if (mode == 3) begin
        ra = ra >>> $urandom_range(0, 31);
        rb = 32'($signed(rb) >>> $urandom_range(0, 31));
      end
      run_op("rand", ra, rb, model(ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
